// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache with a line-wide req/ack memory port.
// Define DCACHE_STATS_EN to add hit/miss counter outputs.
module dcache_wb #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     access_i,
  input  logic [ADDR_WIDTH-1:0]    addr_i,
  input  logic                     wr_en_i,
  input  logic [1:0]               wr_size_i,
  input  logic [31:0]              wr_data_i,
  output logic [31:0]              rd_data_o,
  output logic                     hit_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  output logic [32*LINE_WORDS-1:0] mem_wr_data_o,
  input  logic [32*LINE_WORDS-1:0] mem_rd_data_i,
`ifdef DCACHE_STATS_EN
  output logic [31:0]              hit_count_o,
  output logic [31:0]              miss_count_o,
  input  logic                     mem_ack_i
`else
  input  logic                     mem_ack_i
`endif
);

  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int LSB_W  = WSEL_W + 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

  state_e               state_r;
  logic [NUM_LINES-1:0] valid_r;
  logic [NUM_LINES-1:0] dirty_r;
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [LINE_W-1:0]    data_r [NUM_LINES];
  logic [TAG_W-1:0]     fill_tag_r;
  logic [IDX_W-1:0]     fill_idx_r;

  logic [TAG_W-1:0]     req_tag_s;
  logic [IDX_W-1:0]     req_idx_s;
  logic [WSEL_W-1:0]    req_wsel_s;
  logic [LSB_W-1:0]     word_lsb_s;
  logic                 lookup_s;
  logic                 miss_s;
  logic                 store_hit_s;
  logic                 refill_done_s;
  logic [31:0]          merged_s;

  // Byte-lane merge of right-aligned store data into the existing word; size 3 writes nothing.
  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] res;
    case (size)
      2'd0: begin
        mask  = 4'b0001 << lane;
        wdata = {4{data[7:0]}};
      end
      2'd1: begin
        mask  = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
      end
      2'd2: begin
        mask  = 4'b1111;
        wdata = data;
      end
      default: begin
        mask  = 4'b0000;
        wdata = data;
      end
    endcase
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = mask[b] ? wdata[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return res;
  endfunction

  assign req_tag_s     = addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx_s     = addr_i[OFF_W +: IDX_W];
  assign req_wsel_s    = addr_i[2 +: WSEL_W];
  assign word_lsb_s    = {req_wsel_s, 5'd0};
  assign lookup_s      = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
  assign miss_s        = (state_r == IDLE) && access_i && !lookup_s;
  assign store_hit_s   = hit_o && wr_en_i;
  assign refill_done_s = (state_r == REFILL) && mem_ack_i;
  assign merged_s      = merge_store(data_r[req_idx_s][word_lsb_s +: 32], wr_data_i,
                                     wr_size_i, addr_i[1:0]);

  // Zero-latency lookup: hit and read word only while idle.
  always_comb begin
    hit_o     = 1'b0;
    rd_data_o = 32'h0000_0000;
    if ((state_r == IDLE) && access_i && lookup_s) begin
      hit_o     = 1'b1;
      rd_data_o = data_r[req_idx_s][word_lsb_s +: 32];
    end else begin
      hit_o     = 1'b0;
      rd_data_o = 32'h0000_0000;
    end
  end

  // Miss FSM, valid/dirty state and registered memory-port outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r       <= IDLE;
      valid_r       <= '0;
      dirty_r       <= '0;
      fill_tag_r    <= '0;
      fill_idx_r    <= '0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wr_data_o <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (store_hit_s) begin
            dirty_r[req_idx_s] <= 1'b1;
          end else if (miss_s) begin
            fill_tag_r <= req_tag_s;
            fill_idx_r <= req_idx_s;
            mem_req_o  <= 1'b1;
            if (valid_r[req_idx_s] && dirty_r[req_idx_s]) begin
              state_r       <= WRITEBACK;
              mem_we_o      <= 1'b1;
              mem_addr_o    <= {tag_r[req_idx_s], req_idx_s, {OFF_W{1'b0}}};
              mem_wr_data_o <= data_r[req_idx_s];
            end else begin
              state_r    <= REFILL;
              mem_we_o   <= 1'b0;
              mem_addr_o <= {req_tag_s, req_idx_s, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            dirty_r[fill_idx_r] <= 1'b0;
            state_r             <= REFILL;
            mem_we_o            <= 1'b0;
            mem_addr_o          <= {fill_tag_r, fill_idx_r, {OFF_W{1'b0}}};
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            valid_r[fill_idx_r] <= 1'b1;
            dirty_r[fill_idx_r] <= 1'b0;
            state_r             <= IDLE;
            mem_req_o           <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_o <= 1'b0;
          mem_we_o  <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (refill_done_s) begin
      data_r[fill_idx_r] <= mem_rd_data_i;
      tag_r[fill_idx_r]  <= fill_tag_r;
    end else if (store_hit_s) begin
      data_r[req_idx_s][word_lsb_s +: 32] <= merged_s;
    end
  end

`ifdef DCACHE_STATS_EN
  // Free-running hit/miss statistics, wrapping at 2^32.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hit_count_o  <= 32'd0;
      miss_count_o <= 32'd0;
    end else begin
      if (hit_o) begin
        hit_count_o <= hit_count_o + 32'd1;
      end
      if (miss_s) begin
        miss_count_o <= miss_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Directed self-checking bench for dcache_wb (default parameters); stats checks when DCACHE_STATS_EN is defined.
module tb_dcache_wb;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b0;
  logic         access_i = 1'b0;
  logic [31:0]  addr_i = 32'h0;
  logic         wr_en_i = 1'b0;
  logic [1:0]   wr_size_i = 2'd0;
  logic [31:0]  wr_data_i = 32'h0;
  logic [31:0]  rd_data_o;
  logic         hit_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wr_data_o;
  logic [127:0] mem_rd_data_i = 128'h0;
  logic         mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count_o;
  logic [31:0]  miss_count_o;
`endif

  int checks = 0;
  int errors = 0;

  dcache_wb dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .access_i      (access_i),
    .addr_i        (addr_i),
    .wr_en_i       (wr_en_i),
    .wr_size_i     (wr_size_i),
    .wr_data_i     (wr_data_i),
    .rd_data_o     (rd_data_o),
    .hit_o         (hit_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_rd_data_i (mem_rd_data_i),
`ifdef DCACHE_STATS_EN
    .hit_count_o   (hit_count_o),
    .miss_count_o  (miss_count_o),
`endif
    .mem_ack_i     (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic acc, input logic [31:0] a, input logic we,
                       input logic [1:0] sz, input logic [31:0] d);
    access_i  = acc;
    addr_i    = a;
    wr_en_i   = we;
    wr_size_i = sz;
    wr_data_i = d;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!mem_req_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("mem_req_seen", {127'd0, mem_req_o}, 128'd1);
  endtask

  task automatic ack_line(input logic [127:0] line);
    mem_rd_data_i = line;
    mem_ack_i     = 1'b1;
    @(negedge clk_i);
    mem_ack_i     = 1'b0;
  endtask

  initial begin
    #1 reset_i = 1'b1;
    @(negedge clk_i);
    check("rst_hit", {127'd0, hit_o}, 128'd0);
    check("rst_req", {127'd0, mem_req_o}, 128'd0);
    check("rst_we", {127'd0, mem_we_o}, 128'd0);
    check("rst_addr", {96'd0, mem_addr_o}, 128'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Clean miss on 0x100, ack three cycles after the request.
    drive(1'b1, 32'h100, 1'b0, 2'd2, 32'h0);
    #1 check("miss_hit0", {127'd0, hit_o}, 128'd0);
    wait_req();
    check("refill_we", {127'd0, mem_we_o}, 128'd0);
    check("refill_addr", {96'd0, mem_addr_o}, 128'h100);
    @(negedge clk_i);
    @(negedge clk_i);
    check("refill_wait_hit", {127'd0, hit_o}, 128'd0);
    ack_line({32'hD, 32'hC, 32'hB, 32'hA});
    check("fill_hit", {127'd0, hit_o}, 128'd1);
    check("fill_rd", {96'd0, rd_data_o}, 128'hA);
    check("fill_req_drop", {127'd0, mem_req_o}, 128'd0);

    // Byte store then load back the merged word.
    drive(1'b1, 32'h102, 1'b1, 2'd0, 32'h55);
    #1 check("sb_hit", {127'd0, hit_o}, 128'd1);
    @(negedge clk_i);
    drive(1'b1, 32'h100, 1'b0, 2'd2, 32'h0);
    #1 check("sb_rd", {96'd0, rd_data_o}, 128'h0055000A);
    check("sb_no_req", {127'd0, mem_req_o}, 128'd0);

    // Half and word stores.
    @(negedge clk_i);
    drive(1'b1, 32'h106, 1'b1, 2'd1, 32'hBEEF);
    @(negedge clk_i);
    drive(1'b1, 32'h108, 1'b1, 2'd2, 32'h12345678);
    @(negedge clk_i);
    drive(1'b1, 32'h104, 1'b0, 2'd2, 32'h0);
    #1 check("sh_rd", {96'd0, rd_data_o}, 128'hBEEF000B);
    addr_i = 32'h108;
    #1 check("sw_rd", {96'd0, rd_data_o}, 128'h12345678);
    addr_i = 32'h10C;
    #1 check("w3_rd", {96'd0, rd_data_o}, 128'hD);

    // Dirty conflict miss on 0x200: writeback then refill, address held stable.
    @(negedge clk_i);
    drive(1'b1, 32'h200, 1'b0, 2'd2, 32'h0);
    wait_req();
    check("wb_we", {127'd0, mem_we_o}, 128'd1);
    check("wb_addr", {96'd0, mem_addr_o}, 128'h100);
    check("wb_data", mem_wr_data_o, {32'hD, 32'h12345678, 32'hBEEF000B, 32'h0055000A});
    addr_i = 32'h340;
    @(negedge clk_i);
    check("wb_addr_stable", {96'd0, mem_addr_o}, 128'h100);
    check("wb_hit0", {127'd0, hit_o}, 128'd0);
    addr_i = 32'h200;
    ack_line(128'h0);
    check("wb2rf_req", {127'd0, mem_req_o}, 128'd1);
    check("wb2rf_we", {127'd0, mem_we_o}, 128'd0);
    check("wb2rf_addr", {96'd0, mem_addr_o}, 128'h200);
    addr_i = 32'h500;
    @(negedge clk_i);
    check("rf_addr_stable", {96'd0, mem_addr_o}, 128'h200);
    addr_i = 32'h200;
    ack_line({32'h4, 32'h3, 32'h2, 32'h1});
    check("rf2_hit", {127'd0, hit_o}, 128'd1);
    check("rf2_rd", {96'd0, rd_data_o}, 128'h1);

    // Line now clean: miss on 0x100 refills directly; reset mid-refill abandons it.
    drive(1'b1, 32'h100, 1'b0, 2'd2, 32'h0);
    wait_req();
    check("clean_we", {127'd0, mem_we_o}, 128'd0);
    check("clean_addr", {96'd0, mem_addr_o}, 128'h100);
    @(negedge clk_i);
    reset_i  = 1'b1;
    access_i = 1'b0;
    #1 check("rst_mid_req", {127'd0, mem_req_o}, 128'd0);
    check("rst_mid_addr", {96'd0, mem_addr_o}, 128'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    ack_line({32'h99, 32'h99, 32'h99, 32'h99});
    check("late_ack_req", {127'd0, mem_req_o}, 128'd0);
    access_i = 1'b1;
    #1 check("post_rst_miss", {127'd0, hit_o}, 128'd0);
    wait_req();
    check("post_rst_we", {127'd0, mem_we_o}, 128'd0);

    // Access dropped mid-refill: line still installed.
    access_i = 1'b0;
    @(negedge clk_i);
    ack_line({32'h7A, 32'h79, 32'h78, 32'h77});
    check("drop_hit", {127'd0, hit_o}, 128'd0);
    check("drop_req", {127'd0, mem_req_o}, 128'd0);
    access_i = 1'b1;
    #1 check("drop_later_hit", {127'd0, hit_o}, 128'd1);
    check("drop_later_rd", {96'd0, rd_data_o}, 128'h77);
    addr_i = 32'h200;
    #1 check("evicted_miss", {127'd0, hit_o}, 128'd0);
    access_i = 1'b0;
    @(negedge clk_i);

`ifdef DCACHE_STATS_EN
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("stats_rst_hit", {96'd0, hit_count_o}, 128'd0);
    check("stats_rst_miss", {96'd0, miss_count_o}, 128'd0);
    drive(1'b1, 32'h100, 1'b0, 2'd2, 32'h0);
    wait_req();
    ack_line({32'h4, 32'h3, 32'h2, 32'h1});
    for (int i = 0; i < 4; i++) @(negedge clk_i);
    access_i = 1'b0;
    check("stats_miss", {96'd0, miss_count_o}, 128'd1);
    check("stats_hit", {96'd0, hit_count_o}, 128'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
